// File: rtl/wrr_arb_pkg.sv
// Shared constants and types for the weighted round-robin burst arbiter.
//   N              : default number of requesters
//   WW             : default width of each weight / beat-credit field
//   IDW            : default width of a requester index
//   DEFAULT_WEIGHT : weight applied at reset, and to any weight field of 0
//   state_t        : arbiter FSM state (IDLE, GRANT)
package wrr_arb_pkg;

    localparam int unsigned N              = 4;
    localparam int unsigned WW             = 4;
    localparam int unsigned IDW            = $clog2(N);
    localparam int unsigned DEFAULT_WEIGHT = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : wrr_arb_pkg

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker (purely combinational).
// Scans req from index ptr upward, wrapping modulo N; the first set bit wins.
//   req           [N]   : request vector
//   ptr           [IDW] : index holding highest priority (must be < N)
//   found               : at least one request is set
//   winner        [IDW] : binary index of the winning request
//   winner_onehot [N]   : one-hot form of winner (all zero when !found)
module rr_priority_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner,
    output logic [N-1:0]   winner_onehot
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dreq;

    // Lower copy keeps only requests at or above ptr; upper copy is the
    // unmasked wrap-around. The lowest set bit of the concatenation is the
    // first request found scanning upward from ptr modulo N.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= {{(32-IDW){1'b0}}, ptr});
        end
        dreq = {req, req & mask};

        found         = 1'b0;
        winner        = '0;
        winner_onehot = '0;
        for (int unsigned i = 0; i < 2*N; i++) begin
            if (!found && dreq[i]) begin
                found         = 1'b1;
                winner        = IDW'(i % N);
                winner_onehot = N'(1) << (i % N);
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter.
// Grants one shared resource to one of N requesters. The owner keeps the
// grant for up to weight[owner] beats (a beat is a granted cycle with
// req[owner] high), or until it drops req, then priority rotates to
// owner+1. Handover is back-to-back with no idle cycle when others wait.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req        [N]    : per-requester request
//   cfg_weight [N*WW] : weights, field i at [i*WW +: WW]; 0 behaves as 1
//   cfg_load          : pulse, captures cfg_weight at the edge
//   gnt        [N]    : registered one-hot grant, zero when idle
//   gnt_id     [IDW]  : index of current owner, holds last owner when idle
//   busy              : OR of gnt
module wrr_burst_arbiter #(
    parameter int unsigned N   = wrr_arb_pkg::N,
    parameter int unsigned WW  = wrr_arb_pkg::WW,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] cfg_weight,
    input  logic            cfg_load,
    output logic [N-1:0]    gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy
);

    import wrr_arb_pkg::*;

    state_t         state, state_n;
    logic [IDW-1:0] owner, owner_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] ptr_after;
    logic [IDW-1:0] pick_ptr;
    logic [WW-1:0]  credit, credit_n;
    logic [WW-1:0]  load_credit;
    logic [WW-1:0]  weight [N];
    logic [N-1:0]   gnt_n;

    logic           found;
    logic [IDW-1:0] winner;
    logic [N-1:0]   winner_onehot;
    logic           beat;
    logic           last_beat;

    assign ptr_after = (owner == IDW'(N-1)) ? '0 : owner + 1'b1;

    // While granted, the picker only matters on release, where the scan
    // starts just past the owner; in IDLE it starts at the stored pointer.
    // One picker serves both cases.
    assign pick_ptr = (state == GRANT) ? ptr_after : ptr;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req           (req),
        .ptr           (pick_ptr),
        .found         (found),
        .winner        (winner),
        .winner_onehot (winner_onehot)
    );

    // Credit loads from the registered weights, so a cfg_load on the same
    // edge still loads the old value.
    assign load_credit = (weight[winner] == '0) ? WW'(DEFAULT_WEIGHT)
                                                : weight[winner];

    assign beat      = req[owner];
    assign last_beat = (credit == WW'(1));

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        credit_n = credit;
        gnt_n    = gnt;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n  = GRANT;
                    owner_n  = winner;
                    credit_n = load_credit;
                    gnt_n    = winner_onehot;
                end
            end

            GRANT: begin
                if (beat && !last_beat) begin
                    credit_n = credit - 1'b1;
                end else begin
                    // Burst exhausted or owner dropped req: rotate and hand
                    // over in the same cycle.
                    ptr_n = ptr_after;
                    if (found) begin
                        owner_n  = winner;
                        credit_n = load_credit;
                        gnt_n    = winner_onehot;
                    end else begin
                        state_n  = IDLE;
                        credit_n = '0;
                        gnt_n    = '0;
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                credit_n = '0;
                gnt_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            credit <= '0;
            gnt    <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                weight[i] <= WW'(DEFAULT_WEIGHT);
            end
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            credit <= credit_n;
            gnt    <= gnt_n;
            if (cfg_load) begin
                for (int unsigned i = 0; i < N; i++) begin
                    weight[i] <= cfg_weight[i*WW +: WW];
                end
            end
        end
    end

    assign gnt_id = owner;
    assign busy   = |gnt;

endmodule : wrr_burst_arbiter

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter (N=4, WW=4).
// Each scenario task builds a per-cycle table of inputs and expected grant,
// pushes the expectation into a scoreboard as the inputs are driven, and
// pops and compares once the clock edge has produced the DUT output.
module tb_wrr_burst_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned WW  = 4;
    localparam int unsigned IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*WW-1:0] cfg_weight;
    logic            cfg_load;
    logic [N-1:0]    gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] req;
        logic       load;
        logic       rst;
        logic [3:0] gnt;
        logic [1:0] id;
    } step_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];

    wrr_burst_arbiter #(
        .N   (N),
        .WW  (WW),
        .IDW (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cfg_weight (cfg_weight),
        .cfg_load   (cfg_load),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic [3:0] r, input logic l,
                                 input logic s, input logic [3:0] g,
                                 input logic [1:0] id);
        step_t st;
        st.req  = r;
        st.load = l;
        st.rst  = s;
        st.gnt  = g;
        st.id   = id;
        return st;
    endfunction

    task automatic apply_reset();
        rst        = 1'b1;
        req        = '0;
        cfg_load   = 1'b0;
        cfg_weight = 16'h1111;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_weights(input logic [15:0] w);
        cfg_weight = w;
        cfg_load   = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic idle_inputs();
        req      = '0;
        cfg_load = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        cfg_weight = 16'h1111;
        st.push_back(mk(4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0));
        st.push_back(mk(4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL reset_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL reset_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        step_t st[$];
        exp_t  e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            st.push_back(mk(4'b1111, 1'b0, 1'b0, 4'(1 << (i % 4)), 2'(i % 4)));
        end
        st.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL rr_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL rr_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_weighted();
        step_t st[$];
        exp_t  e;
        logic [3:0] g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                              4'b0010, 4'b0001, 4'b0001, 4'b0001};
        logic [1:0] d [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        apply_reset();
        load_weights(16'h1123);
        for (int i = 0; i < 8; i++) st.push_back(mk(4'b0011, 1'b0, 1'b0, g[i], d[i]));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL wrr_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL wrr_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL wrr_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_early_release();
        step_t st[$];
        exp_t  e;
        apply_reset();
        st.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
        st.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
        st.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2));
        st.push_back(mk(4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL early_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL early_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL early_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_zero_weight();
        step_t st[$];
        exp_t  e;
        apply_reset();
        load_weights(16'h1101);
        for (int i = 0; i < 4; i++) st.push_back(mk(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1));
        st.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1));
        for (int i = 0; i < 4; i++) begin
            st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'(1 << (i % 2)), 2'(i % 2)));
        end
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL w0_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL w0_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL w0_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_cfg_midburst();
        step_t st[$];
        exp_t  e;
        apply_reset();
        load_weights(16'h1114);
        cfg_weight = 16'h1111;
        for (int i = 0; i < 4; i++) st.push_back(mk(4'b0011, 1'(i == 1), 1'b0, 4'b0001, 2'd0));
        for (int i = 0; i < 4; i++) begin
            st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'(2 >> (i % 2)), 2'((i + 1) % 2)));
        end
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL cfgmid_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL cfgmid_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL cfgmid_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_cfg_coincident();
        step_t st[$];
        exp_t  e;
        apply_reset();
        cfg_weight = 16'h1113;
        st.push_back(mk(4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1));
        for (int i = 0; i < 3; i++) st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL cfgco_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL cfgco_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL cfgco_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_max_burst();
        step_t st[$];
        exp_t  e;
        apply_reset();
        load_weights(16'h111F);
        for (int i = 0; i < 15; i++) st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1));
        st.push_back(mk(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL max_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL max_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL max_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midburst();
        step_t st[$];
        exp_t  e;
        apply_reset();
        load_weights(16'h1113);
        st.push_back(mk(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b1000, 1'b0, 1'b1, 4'b0000, 2'd0));
        st.push_back(mk(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3));
        st.push_back(mk(4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0));
        st.push_back(mk(4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3));
        foreach (st[c]) begin
            req = st[c].req; cfg_load = st[c].load; rst = st[c].rst;
            sb.push_back({st[c].gnt, st[c].id});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin failures++; $display("FAIL rstmid_gnt cyc=%0d got=%b exp=%b", c, gnt, e.gnt); end
            checks++;
            if (gnt_id !== e.id) begin failures++; $display("FAIL rstmid_id cyc=%0d got=%0d exp=%0d", c, gnt_id, e.id); end
            checks++;
            if (busy !== (|e.gnt)) begin failures++; $display("FAIL rstmid_busy cyc=%0d got=%b exp=%b", c, busy, |e.gnt); end
        end
        idle_inputs();
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        cfg_load   = 1'b0;
        cfg_weight = 16'h1111;
        test_reset();
        test_round_robin();
        test_weighted();
        test_early_release();
        test_zero_weight();
        test_cfg_midburst();
        test_cfg_coincident();
        test_max_burst();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_wrr_burst_arbiter
